// File: rtl/audio_frame_serializer_if.sv
// Sample/serial bundle between the music player and the codec-side
// serializer. The player side drives the sample and enable and receives
// the frame request, the serial pins and the underrun flag.
interface audio_frame_serializer_if;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        new_frame;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  modport master (
    output enable,
    output sample_in,
    output sample_valid,
    input  new_frame,
    input  bclk,
    input  lrclk,
    input  sdata,
    input  underrun
  );

  modport slave (
    input  enable,
    input  sample_in,
    input  sample_valid,
    output new_frame,
    output bclk,
    output lrclk,
    output sdata,
    output underrun
  );
endinterface

// File: rtl/audio_frame_serializer.sv
// Codec-side serial audio transmitter. Divides clk down to a bit clock,
// runs a 32-slot frame (16 left + 16 right, left-justified, MSB first),
// requests one mono sample per frame and sends it in both channels.
// Every output is a flop; all slot updates happen on bclk falling
// transitions so sdata/lrclk are stable around each rising bclk.
module audio_frame_serializer #(
  parameter int BCLK_HALF = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  audio_frame_serializer_if.slave  bus
);

  localparam int                DIV_W    = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  // Registered state
  logic [DIV_W-1:0] div_r;
  logic             bclk_r;
  logic [4:0]       bit_cnt_r;
  logic             lrclk_r;
  logic             sdata_r;
  logic             new_frame_r;
  logic             underrun_r;
  logic [15:0]      sample_r;
  logic             fresh_r;

  // Next-state values
  logic [DIV_W-1:0] div_nxt_s;
  logic             bclk_nxt_s;
  logic [4:0]       bit_cnt_nxt_s;
  logic             lrclk_nxt_s;
  logic             sdata_nxt_s;
  logic             new_frame_nxt_s;
  logic             underrun_nxt_s;
  logic [15:0]      sample_nxt_s;
  logic             fresh_nxt_s;

  // Decoded events
  logic             div_wrap_s;
  logic             fall_s;
  logic [4:0]       bit_cnt_inc_s;
  logic             frame_req_s;
  logic             latch_s;
  logic             take_s;

  // Serial bit carried by a slot: slots 0..15 and 16..31 both walk the
  // sample from bit 15 down to bit 0, so only the low four slot bits matter.
  function automatic logic slot_bit(input logic [15:0] smp, input logic [4:0] slot);
    logic [3:0] idx;
    idx = 4'd15 - slot[3:0];
    return smp[idx];
  endfunction

  // Event decode: divider wrap, bclk fall event, request and latch points
  always_comb begin
    div_wrap_s    = (div_r == DIV_LAST);
    fall_s        = div_wrap_s & bclk_r;
    bit_cnt_inc_s = bit_cnt_r + 5'd1;
    frame_req_s   = fall_s & (bit_cnt_inc_s == 5'd31);
    latch_s       = fall_s & (bit_cnt_inc_s == 5'd0);
    // A pulse in the latch cycle itself still counts as a fresh sample
    take_s        = fresh_r | bus.sample_valid;
  end

  // Next-state computation for timing, sample capture and serial outputs
  always_comb begin
    div_nxt_s       = div_r;
    bclk_nxt_s      = bclk_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    lrclk_nxt_s     = lrclk_r;
    sdata_nxt_s     = sdata_r;
    underrun_nxt_s  = underrun_r;
    sample_nxt_s    = sample_r;
    fresh_nxt_s     = fresh_r;
    new_frame_nxt_s = frame_req_s;

    if (div_wrap_s) begin
      div_nxt_s  = '0;
      bclk_nxt_s = ~bclk_r;
    end else begin
      div_nxt_s  = div_r + DIV_ONE;
      bclk_nxt_s = bclk_r;
    end

    // The request cycle restarts the freshness window; a pulse coincident
    // with the request is already inside that window.
    if (new_frame_r) begin
      fresh_nxt_s = bus.sample_valid;
    end else if (bus.sample_valid) begin
      fresh_nxt_s = 1'b1;
    end else begin
      fresh_nxt_s = fresh_r;
    end

    if (latch_s && take_s) begin
      sample_nxt_s = bus.sample_in;
    end else begin
      sample_nxt_s = sample_r;
    end

    // Missing sample is only an error while actually transmitting
    if (latch_s && !take_s && bus.enable) begin
      underrun_nxt_s = 1'b1;
    end else begin
      underrun_nxt_s = underrun_r;
    end

    if (fall_s) begin
      bit_cnt_nxt_s = bit_cnt_inc_s;
      lrclk_nxt_s   = bit_cnt_inc_s[4];
      if (bus.enable) begin
        // Uses the just-captured sample so the MSB leaves on the latch edge
        sdata_nxt_s = slot_bit(sample_nxt_s, bit_cnt_inc_s);
      end else begin
        sdata_nxt_s = 1'b0;
      end
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
      lrclk_nxt_s   = lrclk_r;
      sdata_nxt_s   = sdata_r;
    end
  end

  // State register with synchronous reset; reset parks the slot counter
  // at 30 so the first request comes one bit period after release
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r       <= '0;
      bclk_r      <= 1'b0;
      bit_cnt_r   <= 5'd30;
      lrclk_r     <= 1'b1;
      sdata_r     <= 1'b0;
      new_frame_r <= 1'b0;
      underrun_r  <= 1'b0;
      sample_r    <= 16'h0000;
      fresh_r     <= 1'b0;
    end else begin
      div_r       <= div_nxt_s;
      bclk_r      <= bclk_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      lrclk_r     <= lrclk_nxt_s;
      sdata_r     <= sdata_nxt_s;
      new_frame_r <= new_frame_nxt_s;
      underrun_r  <= underrun_nxt_s;
      sample_r    <= sample_nxt_s;
      fresh_r     <= fresh_nxt_s;
    end
  end

  assign bus.bclk      = bclk_r;
  assign bus.lrclk     = lrclk_r;
  assign bus.sdata     = sdata_r;
  assign bus.new_frame = new_frame_r;
  assign bus.underrun  = underrun_r;

endmodule
